// File: rtl/renkon_ctrl_sched_pkg.sv
// Shared renkon definitions: default loop widths, watchdog slack, control bus
// delay width and the scheduler state encoding.
package renkon_ctrl_sched_pkg;

  localparam int LWIDTH      = 10;  // channel-count width
  localparam int FWIDTH      = 12;  // pixel-count width
  localparam int TO_MARGIN   = 64;  // watchdog slack in cycles
  localparam int CTRL_DWIDTH = 16;  // width of the ctrl_bus delay field

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } sched_state_e;

endpackage

// File: rtl/ctrl_bus.sv
// Pipeline control bus: start/valid/stop framing, a latency hint (delay) from
// the producer side and a ready back-pressure signal from the consumer side.
interface ctrl_bus;

  logic                                         start;
  logic                                         valid;
  logic                                         stop;
  logic                                         ready;
  logic [renkon_ctrl_sched_pkg::CTRL_DWIDTH-1:0] delay;

  modport master (output start, output valid, output stop, output delay, input ready);
  modport slave  (input start, input valid, input stop, input delay, output ready);

endinterface

// File: rtl/renkon_sched_cnt.sv
// Nested pixel/input-channel loop counter. pix_idx is the inner loop and
// carries into in_idx; both wrap to zero after the last pixel of the last
// input channel. Counters hold whenever adv is low.
module renkon_sched_cnt #(
  parameter int LWIDTH = 10,
  parameter int FWIDTH = 12
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              clr,
  input  logic              adv,
  input  logic [LWIDTH-1:0] in_size,
  input  logic [FWIDTH-1:0] fea_size,
  output logic [LWIDTH-1:0] in_idx,
  output logic [FWIDTH-1:0] pix_idx,
  output logic              pix_last,
  output logic              in_last
);

  logic [LWIDTH-1:0] in_idx_q, in_idx_d;
  logic [FWIDTH-1:0] pix_idx_q, pix_idx_d;

  assign pix_last = (pix_idx_q == fea_size - FWIDTH'(1));
  assign in_last  = (in_idx_q == in_size - LWIDTH'(1));
  assign in_idx   = in_idx_q;
  assign pix_idx  = pix_idx_q;

  // next index: clear wins, otherwise step pixel with carry into channel
  always_comb begin
    in_idx_d  = in_idx_q;
    pix_idx_d = pix_idx_q;
    if (clr) begin
      in_idx_d  = '0;
      pix_idx_d = '0;
    end else if (adv) begin
      if (pix_last) begin
        pix_idx_d = '0;
        in_idx_d  = in_last ? '0 : in_idx_q + LWIDTH'(1);
      end else begin
        pix_idx_d = pix_idx_q + FWIDTH'(1);
      end
    end
  end

  // index registers
  always_ff @(posedge clk) begin
    if (xrst) begin
      in_idx_q  <= '0;
      pix_idx_q <= '0;
    end else begin
      in_idx_q  <= in_idx_d;
      pix_idx_q <= pix_idx_d;
    end
  end

endmodule

// File: rtl/renkon_ctrl_sched.sv
// Layer scheduler: on req, latches layer sizes, then walks out/in/pixel loops,
// issuing one pipeline beat per cycle the head is ready. After the last beat of
// each output channel it waits for the tail to report stop before moving on;
// ack pulses once when the layer is complete.
// Optional build macro RENKON_SCHED_TIMEOUT_EN: adds an S_WAIT watchdog that
// sets the sticky err flag and forces completion when the tail never stops.
module renkon_ctrl_sched #(
  parameter int LWIDTH    = renkon_ctrl_sched_pkg::LWIDTH,
  parameter int FWIDTH    = renkon_ctrl_sched_pkg::FWIDTH,
  parameter int TO_MARGIN = renkon_ctrl_sched_pkg::TO_MARGIN
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              req,
  output logic              ack,
  input  logic [LWIDTH-1:0] _in_size,
  input  logic [LWIDTH-1:0] _out_size,
  input  logic [FWIDTH-1:0] _fea_size,
  input  logic              _relu_en,
  output logic              relu_en,
  output logic [LWIDTH-1:0] in_idx,
  output logic [LWIDTH-1:0] out_idx,
  output logic [FWIDTH-1:0] pix_idx,
  output logic              first_input,
  output logic              last_input,
  ctrl_bus.master           pipe_ctrl,
  ctrl_bus.slave            tail_ctrl,
  output logic              err
);

  import renkon_ctrl_sched_pkg::sched_state_e;
  import renkon_ctrl_sched_pkg::S_IDLE;
  import renkon_ctrl_sched_pkg::S_PREP;
  import renkon_ctrl_sched_pkg::S_RUN;
  import renkon_ctrl_sched_pkg::S_WAIT;
  import renkon_ctrl_sched_pkg::S_DONE;

  sched_state_e      state_q, state_d;
  logic [LWIDTH-1:0] in_size_q, in_size_d;
  logic [LWIDTH-1:0] out_size_q, out_size_d;
  logic [LWIDTH-1:0] out_idx_q, out_idx_d;
  logic [FWIDTH-1:0] fea_size_q, fea_size_d;
  logic              relu_en_q, relu_en_d;

  logic cnt_clr, cnt_adv;
  logic pix_last, in_last;
  logic run_beat, first_beat, stop_beat;
  logic any_zero;
  logic to_hit;

  renkon_sched_cnt #(
    .LWIDTH (LWIDTH),
    .FWIDTH (FWIDTH)
  ) u_cnt (
    .clk      (clk),
    .xrst     (xrst),
    .clr      (cnt_clr),
    .adv      (cnt_adv),
    .in_size  (in_size_q),
    .fea_size (fea_size_q),
    .in_idx   (in_idx),
    .pix_idx  (pix_idx),
    .pix_last (pix_last),
    .in_last  (in_last)
  );

  // a beat issues in any running cycle where the pipeline head can take it
  assign run_beat   = (state_q == S_RUN) && pipe_ctrl.ready;
  assign first_beat = run_beat && (pix_idx == '0) && (in_idx == '0);
  assign stop_beat  = run_beat && pix_last && in_last;

  assign pipe_ctrl.valid = run_beat;
  assign pipe_ctrl.start = first_beat;
  assign pipe_ctrl.stop  = stop_beat;
  assign pipe_ctrl.delay = '0;
  assign tail_ctrl.ready = 1'b1;

  assign first_input = run_beat && (in_idx == '0);
  assign last_input  = run_beat && in_last;
  assign out_idx     = out_idx_q;
  assign relu_en     = relu_en_q;

  // a zero in any dimension means the layer has no work at all
  assign any_zero = (_in_size == '0) || (_out_size == '0) || (_fea_size == '0);

`ifdef RENKON_SCHED_TIMEOUT_EN
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic        err_q, err_d;

  // watchdog fires on the last allowed S_WAIT cycle unless the tail stops then
  assign to_hit = (state_q == S_WAIT) && !tail_ctrl.stop &&
                  ((wait_cnt_q + 32'd1) >= (32'(tail_ctrl.delay) + 32'(TO_MARGIN)));

  // count cycles spent in S_WAIT; err latches on the first expiry
  always_comb begin
    wait_cnt_d = (state_q == S_WAIT) ? wait_cnt_q + 32'd1 : 32'd0;
    err_d      = err_q | to_hit;
  end

  // watchdog registers
  always_ff @(posedge clk) begin
    if (xrst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;

  logic unused_tail;
  assign unused_tail = ^{tail_ctrl.start, tail_ctrl.valid};
`else
  assign to_hit = 1'b0;
  assign err    = 1'b0;

  logic unused_tail;
  assign unused_tail = ^{tail_ctrl.start, tail_ctrl.valid, tail_ctrl.delay, 32'(TO_MARGIN)};
`endif

  // next-state, size latching and loop control
  always_comb begin
    state_d    = state_q;
    in_size_d  = in_size_q;
    out_size_d = out_size_q;
    fea_size_d = fea_size_q;
    out_idx_d  = out_idx_q;
    relu_en_d  = relu_en_q;
    cnt_clr    = 1'b0;
    cnt_adv    = 1'b0;
    ack        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) state_d = S_PREP;
      end
      S_PREP: begin
        in_size_d  = _in_size;
        out_size_d = _out_size;
        fea_size_d = _fea_size;
        relu_en_d  = _relu_en;
        out_idx_d  = '0;
        cnt_clr    = 1'b1;
        state_d    = any_zero ? S_DONE : S_RUN;
      end
      S_RUN: begin
        cnt_adv = run_beat;
        if (stop_beat) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tail_ctrl.stop) begin
          if (out_idx_q == out_size_q - LWIDTH'(1)) begin
            state_d = S_DONE;
          end else begin
            out_idx_d = out_idx_q + LWIDTH'(1);
            cnt_clr   = 1'b1;
            state_d   = S_RUN;
          end
        end else if (to_hit) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ack     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and latched layer parameters
  always_ff @(posedge clk) begin
    if (xrst) begin
      state_q    <= S_IDLE;
      in_size_q  <= '0;
      out_size_q <= '0;
      fea_size_q <= '0;
      out_idx_q  <= '0;
      relu_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_size_q  <= in_size_d;
      out_size_q <= out_size_d;
      fea_size_q <= fea_size_d;
      out_idx_q  <= out_idx_d;
      relu_en_q  <= relu_en_d;
    end
  end

endmodule

// File: tb/tb_renkon_ctrl_sched.sv
// Testbench for renkon_ctrl_sched: directed layers plus randomized layers
// (random sizes, head back-pressure, tail latency, stray req/tail stop),
// checked beat-by-beat against an expected loop-nest sequence.
module tb_renkon_ctrl_sched;

  localparam int LW  = 10;
  localparam int FW  = 12;
  localparam int TOM = 64;

  typedef struct {
    int o;
    int i;
    int p;
    bit st;
    bit sp;
    bit fi;
    bit la;
  } beat_t;

  logic          clk = 1'b0;
  logic          xrst;
  logic          req;
  logic          ack;
  logic [LW-1:0] in_size_i;
  logic [LW-1:0] out_size_i;
  logic [FW-1:0] fea_size_i;
  logic          relu_i;
  logic          relu_en;
  logic [LW-1:0] in_idx;
  logic [LW-1:0] out_idx;
  logic [FW-1:0] pix_idx;
  logic          first_input;
  logic          last_input;
  logic          err;

  ctrl_bus pipe_if ();
  ctrl_bus tail_if ();

  int    n_chk  = 0;
  int    n_fail = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  renkon_ctrl_sched #(
    .LWIDTH    (LW),
    .FWIDTH    (FW),
    .TO_MARGIN (TOM)
  ) dut (
    .clk         (clk),
    .xrst        (xrst),
    .req         (req),
    .ack         (ack),
    ._in_size    (in_size_i),
    ._out_size   (out_size_i),
    ._fea_size   (fea_size_i),
    ._relu_en    (relu_i),
    .relu_en     (relu_en),
    .in_idx      (in_idx),
    .out_idx     (out_idx),
    .pix_idx     (pix_idx),
    .first_input (first_input),
    .last_input  (last_input),
    .pipe_ctrl   (pipe_if.master),
    .tail_ctrl   (tail_if.slave),
    .err         (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ack"},     ack, 1'b0);
    chk({tag, "_valid"},   pipe_if.valid, 1'b0);
    chk({tag, "_start"},   pipe_if.start, 1'b0);
    chk({tag, "_stop"},    pipe_if.stop, 1'b0);
    chk({tag, "_first"},   first_input, 1'b0);
    chk({tag, "_last"},    last_input, 1'b0);
    chk({tag, "_in_idx"},  in_idx, 0);
    chk({tag, "_out_idx"}, out_idx, 0);
    chk({tag, "_pix_idx"}, pix_idx, 0);
    chk({tag, "_relu"},    relu_en, 1'b0);
    chk({tag, "_err"},     err, 1'b0);
  endtask

  // One full layer. sf/sl: forced ready-low window (cycles from req), pct:
  // random ready-low percentage, lag: tail stop delay after head stop (<0 =
  // withheld), tdel: tail delay field, noise: stray req / tail stop.
  task automatic run_layer(input int ni, input int no, input int nf, input bit rl,
                           input int sf, input int sl, input int pct,
                           input int lag, input int tdel, input bit noise);
    int    stop_c, tail_at, exp_ack, ack_c, n_beats, n_start, n_stop, budget;
    bit    zero, in_wait, run_ph, exp_err;
    beat_t b;

    exp_q.delete();
    for (int o = 0; o < no; o++)
      for (int i = 0; i < ni; i++)
        for (int p = 0; p < nf; p++) begin
          b.o  = o;
          b.i  = i;
          b.p  = p;
          b.st = (i == 0) && (p == 0);
          b.sp = (i == ni - 1) && (p == nf - 1);
          b.fi = (i == 0);
          b.la = (i == ni - 1);
          exp_q.push_back(b);
        end

    zero    = (ni == 0) || (no == 0) || (nf == 0);
    stop_c  = -1;
    tail_at = -1;
    exp_ack = zero ? 2 : -1;
    ack_c   = -1;
    n_beats = 0;
    n_start = 0;
    n_stop  = 0;
    budget  = 8 * (ni * no * nf + 1) + no * ((lag > 0 ? lag : 0) + 4) + tdel + TOM + 50;

    @(negedge clk);
    in_size_i     = LW'(ni);
    out_size_i    = LW'(no);
    fea_size_i    = FW'(nf);
    relu_i        = rl;
    req           = 1'b1;
    pipe_if.ready = 1'b1;
    tail_if.stop  = 1'b0;
    tail_if.delay = 16'(tdel);
    #1;
    chk("ack_at_req", ack, 1'b0);

    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      in_wait       = (stop_c >= 0);
      req           = noise && (k > 2) && ($urandom_range(0, 7) == 0);
      pipe_if.ready = !(k >= sf && k < sf + sl) && ($urandom_range(0, 99) >= pct);
      tail_if.stop  = (k == tail_at) || (noise && !in_wait && ($urandom_range(0, 5) == 0));
      tail_if.start = noise && ($urandom_range(0, 3) == 0);
      tail_if.valid = noise && ($urandom_range(0, 1) == 0);
      #1;
      run_ph = !zero && (k >= 2) && !in_wait && (exp_q.size() > 0);

      if (run_ph) chk("valid_run", pipe_if.valid, pipe_if.ready);
      else        chk("valid_off", pipe_if.valid, 1'b0);

      if (pipe_if.valid && exp_q.size() > 0) begin
        b = exp_q.pop_front();
        n_beats++;
        n_start += int'(pipe_if.start);
        n_stop  += int'(pipe_if.stop);
        chk("out_idx", out_idx, b.o);
        chk("in_idx",  in_idx,  b.i);
        chk("pix_idx", pix_idx, b.p);
        chk("start",   pipe_if.start, b.st);
        chk("stop",    pipe_if.stop,  b.sp);
        chk("first",   first_input,   b.fi);
        chk("last",    last_input,    b.la);
        if (b.sp) begin
          stop_c = k;
          if (lag >= 0) tail_at = k + lag;
          if (exp_q.size() == 0) exp_ack = (lag >= 0) ? tail_at + 1 : k + 1 + tdel + TOM;
        end
      end else begin
        chk("start_idle", pipe_if.start, 1'b0);
        chk("stop_idle",  pipe_if.stop,  1'b0);
        chk("first_idle", first_input,   1'b0);
        chk("last_idle",  last_input,    1'b0);
        if (run_ph) begin
          chk("hold_out_idx", out_idx, exp_q[0].o);
          chk("hold_in_idx",  in_idx,  exp_q[0].i);
          chk("hold_pix_idx", pix_idx, exp_q[0].p);
        end
      end

      if (k == tail_at) begin
        stop_c  = -1;
        tail_at = -1;
      end

      exp_err = (lag < 0) && (exp_ack >= 0) && (k >= exp_ack);
      chk("err", err, exp_err);
      chk("pipe_delay", pipe_if.delay, 0);
      chk("tail_ready", tail_if.ready, 1'b1);
      if (k >= 2) chk("relu_en", relu_en, rl);
      chk("ack", ack, (k == exp_ack));
      if (ack) begin
        ack_c = k;
        break;
      end
    end

    chk("ack_seen", (ack_c >= 0), 1'b1);
    chk("n_beats",  n_beats, zero ? 0 : ni * no * nf);
    chk("n_start",  n_start, zero ? 0 : no);
    chk("n_stop",   n_stop,  zero ? 0 : no);
    chk("beats_left", exp_q.size(), 0);

    @(negedge clk);
    req           = 1'b0;
    tail_if.stop  = 1'b0;
    tail_if.start = 1'b0;
    tail_if.valid = 1'b0;
    #1;
    chk("ack_pulse", ack, 1'b0);
    $display("layer in=%0d out=%0d fea=%0d relu=%0d lag=%0d beats=%0d starts=%0d ack_cycle=%0d err=%0d",
             ni, no, nf, rl, lag, n_beats, n_start, ack_c, err);
  endtask

  // abort a layer with reset while beats are flowing
  task automatic reset_mid();
    @(negedge clk);
    in_size_i     = LW'(2);
    out_size_i    = LW'(3);
    fea_size_i    = FW'(4);
    relu_i        = 1'b1;
    req           = 1'b1;
    pipe_if.ready = 1'b1;
    tail_if.stop  = 1'b0;
    @(negedge clk);
    req = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("mid_valid", pipe_if.valid, 1'b1);
    chk("mid_relu",  relu_en, 1'b1);
    xrst = 1'b1;
    @(negedge clk);
    #1;
    chk_idle_outputs("mid_rst");
    xrst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("post_rst_ack",   ack, 1'b0);
      chk("post_rst_valid", pipe_if.valid, 1'b0);
    end
    $display("reset mid-run: outputs cleared, no ack");
  endtask

  initial begin
    xrst          = 1'b1;
    req           = 1'b0;
    relu_i        = 1'b0;
    in_size_i     = '0;
    out_size_i    = '0;
    fea_size_i    = '0;
    pipe_if.ready = 1'b0;
    tail_if.start = 1'b0;
    tail_if.valid = 1'b0;
    tail_if.stop  = 1'b0;
    tail_if.delay = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_idle_outputs("por");
    xrst = 1'b0;

    run_layer(2, 3, 4, 1'b1, 0, 0, 0, 10, 5, 1'b0);
    run_layer(1, 1, 1, 1'b0, 0, 0, 0, 3, 2, 1'b0);
    run_layer(2, 1, 4, 1'b1, 4, 5, 0, 6, 0, 1'b0);
    run_layer(2, 0, 4, 1'b0, 0, 0, 0, 1, 0, 1'b0);
    run_layer(0, 2, 3, 1'b1, 0, 0, 0, 1, 0, 1'b0);
    run_layer(3, 2, 0, 1'b0, 0, 0, 0, 1, 0, 1'b0);

    reset_mid();
    run_layer(2, 3, 4, 1'b0, 0, 0, 0, 4, 1, 1'b1);

    for (int n = 0; n < 12; n++) begin
      run_layer(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
                int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)),
                0, 0, 30, int'($urandom_range(1, 12)),
                int'($urandom_range(0, 15)), 1'b1);
    end

`ifdef RENKON_SCHED_TIMEOUT_EN
    run_layer(1, 1, 2, 1'b1, 0, 0, 0, -1, 8, 1'b0);
    @(negedge clk);
    xrst = 1'b1;
    @(negedge clk);
    #1;
    chk("err_cleared", err, 1'b0);
    xrst = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
